// File: rtl/result_collector_if.sv
// Flit channel between the router local port (r0/v0/f0) and the collector.
interface result_collector_if;
  logic [15:0] i_rdata;
  logic        i_rvalid;
  logic        o_rcredit;

  // Router side: drives flits, observes credit.
  modport master (
    output i_rdata,
    output i_rvalid,
    input  o_rcredit
  );

  // Collector side: consumes flits, returns credit.
  modport slave (
    input  i_rdata,
    input  i_rvalid,
    output o_rcredit
  );
endinterface

// File: rtl/result_collector.sv
// Node-0 result collector: buffers worker flits in a credit-controlled FIFO,
// accumulates one partial result per worker and reports done/timeout/error.
module result_collector #(
  parameter int         NUM_WORKERS    = 8,
  parameter logic [7:0] EXPECT_MASK    = 8'hFF,
  parameter int         TIMEOUT_CYCLES = 50_000_000,
  parameter int         FIFO_DEPTH     = 4          // power of two, >= 2
) (
  input  logic                CLOCK_50,
  input  logic                rst,                  // synchronous, active-low
  input  logic                i_start,
  result_collector_if.slave   flit,
  output logic [15:0]         o_result,
  output logic [7:0]          o_received,
  output logic                o_done,
  output logic                o_timeout,
  output logic                o_error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE, S_TIMEOUT} state_t;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          rcredit_q;
  logic          wr_en;
  logic          pop_en;
  logic          pop_valid_q;
  logic [15:0]   pop_data_q;

  // Credit is only granted while a slot is free, so a write never lands on a full FIFO.
  assign wr_en   = flit.i_rvalid & rcredit_q;
  // Always drain whenever something is buffered, regardless of FSM state.
  assign pop_en  = (count_q != '0);
  assign count_d = count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop_en};

  assign flit.o_rcredit = rcredit_q;

  // Pointer/occupancy bookkeeping; credit follows the occupancy after this edge.
  always_ff @(posedge CLOCK_50) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rcredit_q   <= 1'b1;
      pop_valid_q <= 1'b0;
    end else begin
      if (wr_en)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      rcredit_q   <= (count_d != FULL_COUNT);
      pop_valid_q <= pop_en;
    end
  end

  // Storage array with registered read, kept reset-free so it maps to RAM.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en)  mem_q[wr_ptr_q] <= flit.i_rdata;
    if (pop_en) pop_data_q      <= mem_q[rd_ptr_q];
  end

  // ---------------------------------------------------------------------------
  // Start synchroniser and rising-edge detect
  // ---------------------------------------------------------------------------
  logic start_meta_q;
  logic start_sync_q;
  logic start_prev_q;
  logic start_rise;

  // Two-flop synchroniser plus one delay stage for edge detection.
  always_ff @(posedge CLOCK_50) begin
    if (!rst) begin
      start_meta_q <= 1'b0;
      start_sync_q <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      start_meta_q <= i_start;
      start_sync_q <= start_meta_q;
      start_prev_q <= start_sync_q;
    end
  end

  assign start_rise = start_sync_q & ~start_prev_q;

  // ---------------------------------------------------------------------------
  // Round FSM and accumulator
  // ---------------------------------------------------------------------------
  state_t        state_q;
  state_t        state_d;
  logic [15:0]   result_q;
  logic [15:0]   result_d;
  logic [7:0]    received_q;
  logic [7:0]    received_d;
  logic          done_q;
  logic          done_d;
  logic          timeout_q;
  logic          timeout_d;
  logic          error_q;
  logic          error_d;
  logic [TW-1:0] tcnt_q;
  logic [TW-1:0] tcnt_d;

  logic [3:0]    src;
  logic [7:0]    src_bit;
  logic [7:0]    merged;
  logic          accept;

  // State and status registers.
  always_ff @(posedge CLOCK_50) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      result_q   <= '0;
      received_q <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      error_q    <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      received_q <= received_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      error_q    <= error_d;
      tcnt_q     <= tcnt_d;
    end
  end

  // Next-state logic: classify the popped flit, accumulate, detect done/timeout.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    received_d = received_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    error_d    = error_q;
    tcnt_d     = tcnt_q;

    // One-hot of the source; zero for ID 0 or IDs beyond the worker count.
    src     = pop_data_q[15:12];
    src_bit = '0;
    for (int k = 0; k < 8; k++) begin
      src_bit[k] = (src == 4'(k + 1)) && (k < NUM_WORKERS);
    end
    merged = received_q | src_bit;
    accept = ((src_bit & EXPECT_MASK) != '0) && ((received_q & src_bit) == '0);

    if (start_rise) begin
      // A start edge opens a fresh round from any state; a flit popped in this
      // same cycle belongs to the abandoned round and is dropped silently.
      state_d    = S_COLLECT;
      result_d   = '0;
      received_d = '0;
      done_d     = 1'b0;
      timeout_d  = 1'b0;
      error_d    = 1'b0;
      tcnt_d     = '0;
    end else begin
      case (state_q)
        S_COLLECT: begin
          if (tcnt_q != T_LAST) tcnt_d = tcnt_q + 1'b1;
          if (pop_valid_q) begin
            if (accept) begin
              result_d   = result_q + {4'b0, pop_data_q[11:0]};
              received_d = merged;
              if ((merged & EXPECT_MASK) == EXPECT_MASK) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end
            end else begin
              error_d = 1'b1;
            end
          end
          // Completion in the final cycle takes priority over timeout.
          if ((state_d == S_COLLECT) && (tcnt_q == T_LAST)) begin
            state_d   = S_TIMEOUT;
            timeout_d = 1'b1;
          end
        end
        default: begin
          // Any flit outside a collecting round is a stray.
          if (pop_valid_q) error_d = 1'b1;
        end
      endcase
    end
  end

  assign o_result   = result_q;
  assign o_received = received_q;
  assign o_done     = done_q;
  assign o_timeout  = timeout_q;
  assign o_error    = error_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed testbench for result_collector (TIMEOUT_CYCLES shortened to 100).
module tb_result_collector;

  logic        CLOCK_50;
  logic        rst;
  logic        i_start;
  logic [15:0] o_result;
  logic [7:0]  o_received;
  logic        o_done;
  logic        o_timeout;
  logic        o_error;

  int vec_cnt = 0;
  int err_cnt = 0;

  result_collector_if bus ();

  result_collector #(
    .NUM_WORKERS   (8),
    .EXPECT_MASK   (8'hFF),
    .TIMEOUT_CYCLES(100),
    .FIFO_DEPTH    (4)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .rst       (rst),
    .i_start   (i_start),
    .flit      (bus.slave),
    .o_result  (o_result),
    .o_received(o_received),
    .o_done    (o_done),
    .o_timeout (o_timeout),
    .o_error   (o_error)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send(input logic [15:0] f);
    bus.i_rdata  = f;
    bus.i_rvalid = 1'b1;
    tick();
    $display("flit 0x%h driven, credit now %0b", f, bus.o_rcredit);
  endtask

  task automatic idle(input int n);
    bus.i_rvalid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Leaves the DUT in its first COLLECT cycle (state entered on the last edge).
  task automatic start_round();
    i_start = 1'b1;
    tick();
    tick();
    tick();
    i_start = 1'b0;
    $display("round started");
  endtask

  task automatic test_reset();
    rst = 1'b0; i_start = 1'b0; bus.i_rvalid = 1'b0; bus.i_rdata = 16'h0000;
    tick();
    tick();
    rst = 1'b1;
    tick();
    vec_cnt++; if (bus.o_rcredit !== 1'b1) begin err_cnt++; $display("FAIL reset_credit: got %b expected 1", bus.o_rcredit); end
    vec_cnt++; if (o_result !== 16'd0) begin err_cnt++; $display("FAIL reset_result: got %0d expected 0", o_result); end
    vec_cnt++; if (o_received !== 8'h00) begin err_cnt++; $display("FAIL reset_received: got %h expected 00", o_received); end
    vec_cnt++; if ({o_done, o_timeout, o_error} !== 3'b000) begin err_cnt++; $display("FAIL reset_status: got %b expected 000", {o_done, o_timeout, o_error}); end
    $display("test_reset complete");
  endtask

  task automatic test_stray_idle();
    send(16'h1001);
    idle(1);
    vec_cnt++; if (o_error !== 1'b0) begin err_cnt++; $display("FAIL stray_early: got %b expected 0", o_error); end
    idle(1);
    vec_cnt++; if (o_error !== 1'b1) begin err_cnt++; $display("FAIL stray_idle_error: got %b expected 1", o_error); end
    vec_cnt++; if (o_result !== 16'd0) begin err_cnt++; $display("FAIL stray_idle_result: got %0d expected 0", o_result); end
    $display("test_stray_idle complete");
  endtask

  task automatic test_full_round();
    start_round();
    vec_cnt++; if (o_error !== 1'b0) begin err_cnt++; $display("FAIL full_start_clear: got %b expected 0", o_error); end
    send(16'h1005); send(16'h2010); send(16'h3017); send(16'h4020);
    send(16'h5029); send(16'h6030); send(16'h7039); send(16'h8040);
    idle(1);
    vec_cnt++; if (o_received !== 8'h7F) begin err_cnt++; $display("FAIL full_recv7: got %h expected 7f", o_received); end
    vec_cnt++; if (o_result !== 16'd222) begin err_cnt++; $display("FAIL full_sum7: got %0d expected 222", o_result); end
    vec_cnt++; if (o_done !== 1'b0) begin err_cnt++; $display("FAIL full_done_early: got %b expected 0", o_done); end
    idle(1);
    vec_cnt++; if (o_done !== 1'b1) begin err_cnt++; $display("FAIL full_done: got %b expected 1", o_done); end
    vec_cnt++; if (o_result !== 16'd286) begin err_cnt++; $display("FAIL full_result: got %0d expected 286", o_result); end
    vec_cnt++; if (o_received !== 8'hFF) begin err_cnt++; $display("FAIL full_received: got %h expected ff", o_received); end
    vec_cnt++; if ({o_error, o_timeout} !== 2'b00) begin err_cnt++; $display("FAIL full_err_to: got %b expected 00", {o_error, o_timeout}); end
    $display("test_full_round complete");
  endtask

  task automatic test_dup_bad_id();
    start_round();
    vec_cnt++; if ({o_done, o_result} !== 17'd0) begin err_cnt++; $display("FAIL dup_start_clear: got %h expected 0", {o_done, o_result}); end
    send(16'h3007);
    send(16'h3009);
    send(16'h0001);
    vec_cnt++; if (o_result !== 16'd7) begin err_cnt++; $display("FAIL dup_first: got %0d expected 7", o_result); end
    vec_cnt++; if (o_error !== 1'b0) begin err_cnt++; $display("FAIL dup_err_early: got %b expected 0", o_error); end
    send(16'h9001);
    vec_cnt++; if (o_error !== 1'b1) begin err_cnt++; $display("FAIL dup_err: got %b expected 1", o_error); end
    idle(2);
    vec_cnt++; if (o_result !== 16'd7) begin err_cnt++; $display("FAIL dup_result: got %0d expected 7", o_result); end
    vec_cnt++; if (o_received !== 8'h04) begin err_cnt++; $display("FAIL dup_received: got %h expected 04", o_received); end
    vec_cnt++; if (o_done !== 1'b0) begin err_cnt++; $display("FAIL dup_done: got %b expected 0", o_done); end
    $display("test_dup_bad_id complete");
  endtask

  task automatic test_timeout();
    int cyc;
    start_round();
    cyc = 0;
    for (int k = 1; k <= 7; k++) begin
      send({4'(k), 12'h001});
      cyc++;
    end
    bus.i_rvalid = 1'b0;
    while (cyc < 99) begin
      tick();
      cyc++;
    end
    vec_cnt++; if (o_timeout !== 1'b0) begin err_cnt++; $display("FAIL timeout_early: got %b expected 0 at cycle 99", o_timeout); end
    tick();
    vec_cnt++; if (o_timeout !== 1'b1) begin err_cnt++; $display("FAIL timeout_flag: got %b expected 1 at cycle 100", o_timeout); end
    vec_cnt++; if (o_done !== 1'b0) begin err_cnt++; $display("FAIL timeout_done: got %b expected 0", o_done); end
    vec_cnt++; if (o_received !== 8'h7F) begin err_cnt++; $display("FAIL timeout_received: got %h expected 7f", o_received); end
    vec_cnt++; if (o_result !== 16'd7) begin err_cnt++; $display("FAIL timeout_result: got %0d expected 7", o_result); end
    vec_cnt++; if (o_error !== 1'b0) begin err_cnt++; $display("FAIL timeout_error: got %b expected 0", o_error); end
    // A flit after the round ended is a stray and must not be accumulated.
    send(16'h8001);
    idle(2);
    vec_cnt++; if (o_error !== 1'b1) begin err_cnt++; $display("FAIL stray_timeout_error: got %b expected 1", o_error); end
    vec_cnt++; if (o_result !== 16'd7) begin err_cnt++; $display("FAIL stray_timeout_result: got %0d expected 7", o_result); end
    $display("test_timeout complete");
  endtask

  task automatic test_restart();
    start_round();
    send(16'h2005);
    send(16'h4006);
    send(16'h0001);
    idle(2);
    vec_cnt++; if (o_result !== 16'd11) begin err_cnt++; $display("FAIL restart_pre_result: got %0d expected 11", o_result); end
    vec_cnt++; if (o_received !== 8'h0A) begin err_cnt++; $display("FAIL restart_pre_recv: got %h expected 0a", o_received); end
    vec_cnt++; if (o_error !== 1'b1) begin err_cnt++; $display("FAIL restart_pre_err: got %b expected 1", o_error); end
    i_start = 1'b1;
    tick();
    tick();
    vec_cnt++; if (o_result !== 16'd11) begin err_cnt++; $display("FAIL restart_hold: got %0d expected 11", o_result); end
    tick();
    i_start = 1'b0;
    vec_cnt++; if ({o_result, o_received, o_error} !== 25'd0) begin err_cnt++; $display("FAIL restart_clear: got %h expected 0", {o_result, o_received, o_error}); end
    send(16'h5003);
    idle(2);
    vec_cnt++; if (o_result !== 16'd3) begin err_cnt++; $display("FAIL restart_result: got %0d expected 3", o_result); end
    vec_cnt++; if (o_received !== 8'h10) begin err_cnt++; $display("FAIL restart_received: got %h expected 10", o_received); end
    vec_cnt++; if (o_error !== 1'b0) begin err_cnt++; $display("FAIL restart_error: got %b expected 0", o_error); end
    $display("test_restart complete");
  endtask

  task automatic test_back_pressure();
    logic [15:0] vecs [4];
    vecs[0] = 16'h1011; vecs[1] = 16'h2022; vecs[2] = 16'h3033; vecs[3] = 16'h4044;
    start_round();
    force dut.pop_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(vecs[i]);
      if (i < 3) begin
        vec_cnt++; if (bus.o_rcredit !== 1'b1) begin err_cnt++; $display("FAIL bp_credit_open%0d: got %b expected 1", i, bus.o_rcredit); end
      end
    end
    vec_cnt++; if (bus.o_rcredit !== 1'b0) begin err_cnt++; $display("FAIL bp_credit_full: got %b expected 0", bus.o_rcredit); end
    // Keep offering a fifth flit; it must not be taken while credit is low.
    for (int i = 0; i < 3; i++) send(16'h5055);
    vec_cnt++; if (bus.o_rcredit !== 1'b0) begin err_cnt++; $display("FAIL bp_credit_hold: got %b expected 0", bus.o_rcredit); end
    vec_cnt++; if (o_received !== 8'h00) begin err_cnt++; $display("FAIL bp_stalled: got %h expected 00", o_received); end
    bus.i_rvalid = 1'b0;
    release dut.pop_en;
    tick();
    vec_cnt++; if (bus.o_rcredit !== 1'b1) begin err_cnt++; $display("FAIL bp_credit_back: got %b expected 1", bus.o_rcredit); end
    idle(5);
    vec_cnt++; if (o_result !== 16'd170) begin err_cnt++; $display("FAIL bp_result: got %0d expected 170", o_result); end
    vec_cnt++; if (o_received !== 8'h0F) begin err_cnt++; $display("FAIL bp_received: got %h expected 0f", o_received); end
    vec_cnt++; if (o_error !== 1'b0) begin err_cnt++; $display("FAIL bp_error: got %b expected 0", o_error); end
    $display("test_back_pressure complete");
  endtask

  task automatic test_reset_mid_round();
    start_round();
    force dut.pop_en = 1'b0;
    send(16'h1001);
    send(16'h2002);
    bus.i_rvalid = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    release dut.pop_en;
    rst = 1'b1;
    tick();
    vec_cnt++; if (bus.o_rcredit !== 1'b1) begin err_cnt++; $display("FAIL midrst_credit: got %b expected 1", bus.o_rcredit); end
    idle(3);
    // Buffered flits must be gone: otherwise they would pop as strays in IDLE.
    vec_cnt++; if ({o_result, o_received, o_error} !== 25'd0) begin err_cnt++; $display("FAIL midrst_discard: got %h expected 0", {o_result, o_received, o_error}); end
    $display("test_reset_mid_round complete");
  endtask

  initial begin
    test_reset();
    test_stray_idle();
    test_full_round();
    test_dup_bad_id();
    test_timeout();
    test_restart();
    test_back_pressure();
    test_reset_mid_round();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/result_collector.md
# result_collector

Local-port consumer for mesh node 0 on the DE1-SoC NoC design. It accepts 16-bit result flits from the eight worker nodes (1..8) after a broadcast round has been launched. It buffers them in a small credit-controlled FIFO and accumulates one partial result per worker. It then presents the round total, with done/timeout status, to the LED/HEX display logic. It replaces the constant `f0 = 1` credit with real flow control.

## Interface
- `NUM_WORKERS`, 8: worker node count; valid source IDs are 1..NUM_WORKERS.
- `EXPECT_MASK`, 8'hFF: bit k-1 set means worker k must report before the round is done.
- `TIMEOUT_CYCLES`, 50_000_000: COLLECT cycles allowed before timeout (1 s at 50 MHz).
- `FIFO_DEPTH`, 4: input buffer depth, power of two.
- `CLOCK_50`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `i_start`  in  1  round start; level input, edge-detected internally.
- `i_rdata`  in  16  flit from router local port (r0); [15:12] source node ID, [11:0] unsigned partial result.
- `i_rvalid`  in  1  flit valid (v0).
- `o_rcredit`  out  1  collector can accept a flit this cycle (drives f0).
- `o_result`  out  16  accumulated sum of the round.
- `o_received`  out  8  bitmap of workers that have reported.
- `o_done`  out  1  all expected workers reported; held until next start.
- `o_timeout`  out  1  round ended by timeout; held until next start.
- `o_error`  out  1  sticky: bad source ID, duplicate, or stray flit since last start.

## Operation
- **FIFO**
  - Write when `i_rvalid & o_rcredit`.
  - `o_rcredit = ~full`, registered from the current occupancy.
  - Read pointer advances one entry per cycle whenever the FIFO is non-empty, in every state. The FIFO is always drained so the mesh never stalls.
- **States: IDLE, COLLECT, DONE, TIMEOUT.**
  - IDLE -> COLLECT on a rising edge of `i_start`. On that edge: clear `o_result`, `o_received`, `o_error`, `o_done`, `o_timeout` and the timeout counter.
  - COLLECT -> DONE when `(o_received | new_bit) & EXPECT_MASK == EXPECT_MASK`.
  - COLLECT -> TIMEOUT when the counter reaches `TIMEOUT_CYCLES-1` without completion. If completion and timeout happen in the same cycle, DONE wins.
  - DONE/TIMEOUT -> COLLECT on the next `i_start` rising edge, with the same clears.
  - A `i_start` rising edge while in COLLECT restarts the round: clear everything and stay in COLLECT.
- **Popped flit in COLLECT, source ID s**
  - s in 1..NUM_WORKERS, bit s-1 clear: `o_result += {4'b0, payload}`, set bit s-1.
  - s = 0, s > NUM_WORKERS, or bit s-1 not in EXPECT_MASK: discard, set `o_error`.
  - Duplicate (bit already set): discard, set `o_error`. The first value is kept.
- **Popped flit in IDLE/DONE/TIMEOUT:** discard, set `o_error` (stray).
- **Arithmetic:** 16-bit unsigned. The maximum 8×4095 = 32760 fits, so no overflow is possible at default parameters.
- **Reset:** empty FIFO, state IDLE, `o_rcredit` = 1 the cycle after reset releases, all other outputs 0. Reset mid-round discards buffered flits.

## Timing
- `i_start` is synchronised by two flops plus an edge detector. The state changes 3 cycles after the `i_start` rise.
- Flit latency:
  - Accepted at edge N, popped at edge N+1.
  - `o_result`/`o_received` update at edge N+2.
  - `o_done` is asserted at edge N+2 for the completing flit.
- Credit:
  - `o_rcredit` drops in the cycle after the write that fills the FIFO.
  - It rises in the cycle after the pop that frees an entry.
  - A simultaneous write and pop leaves occupancy unchanged.
- Throughput is 1 flit/cycle sustained. The FIFO never fills unless the router has already violated credit.
- The timeout counter increments every COLLECT cycle and saturates. `o_timeout` asserts at COLLECT cycle `TIMEOUT_CYCLES`.

## Test plan
- **Reset release:**
  - `rst` low for 2 cycles, then high.
  - Expect all outputs 0, `o_rcredit`=1, state IDLE.
- **Full round:**
  - Pulse `i_start`, then send flits 0x1005, 0x2010, … 0x8040 (sources 1..8, payloads 5, 16, …, 64), one per cycle.
  - Expect `o_received`=8'hFF, `o_result`=exact sum, `o_done`=1 two cycles after the last flit, `o_error`=0.
- **Duplicate and bad ID:**
  - In a round, send 0x3007, 0x3009, 0x0001, 0x9001.
  - Expect `o_result`=7, `o_received`=8'h04, `o_error`=1.
- **Timeout:**
  - Set `TIMEOUT_CYCLES`=100, `EXPECT_MASK`=8'hFF.
  - Send only sources 1..7.
  - Expect `o_timeout`=1 at COLLECT cycle 100, `o_done`=0, `o_received`=8'h7F.
- **Back-pressure:**
  - Force the pop stall via a bench hook (e.g. a testbench force on the read-enable).
  - Drive `i_rvalid` continuously.
  - Expect `o_rcredit`=0 after 4 accepts, no flit lost, and all 4 accumulated once the stall is released.
- **Restart and stray:**
  - Send flit 0x1001 in IDLE: expect `o_error`=1.
  - Pulse `i_start` mid-round: expect `o_result`/`o_received`/`o_error` cleared 3 cycles later and the next flit counted alone.
